spi_frame_ctrl: RTL and testbench

Consumes the byte stream from the SPI slave shift stage (rx byte plus strobe) and decodes command frames into single-cycle register-bus reads and writes. It also produces the tx byte that the SPI slave loads at the start of each outgoing byte. It sits between the SPI slave and the HWAG register file. Frame boundaries come from spi_ss; frames are optionally protected by CRC-8.

---
 rtl/spi_frame_pkg.sv | 28 ++
 rtl/spi_frame_ctrl_crc8_byte_step.sv | 13 +
 rtl/spi_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types, constants and the CRC-8 byte step for the SPI frame controller.
package spi_frame_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CMD_WR_BIT = 7;
  localparam logic [BYTE_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WCRC,
    RDATA,
    RCRC,
    DONE
  } frame_state_e;

  // CRC-8, MSB first, no reflection, no final XOR; one whole byte per call.
  function automatic logic [BYTE_W-1:0] crc8_byte(input logic [BYTE_W-1:0] crc,
                                                 input logic [BYTE_W-1:0] data);
    logic [BYTE_W-1:0] c;
    c = crc ^ data;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      c = c[BYTE_W-1] ? (BYTE_W'(c << 1) ^ CRC_POLY) : BYTE_W'(c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_frame_ctrl_crc8_byte_step.sv
// Combinational next-CRC for one byte; used by spi_frame_ctrl when
// SPI_FRAME_CRC_EN is defined.
module crc8_byte_step
  import spi_frame_pkg::*;
(
  input  logic [BYTE_W-1:0] crc,
  input  logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] crc_next_c
);

  assign crc_next_c = crc8_byte(crc, data);

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI command-frame decoder driving single-cycle register reads/writes.
// Build option: SPI_FRAME_CRC_EN adds a trailing CRC-8 byte to every frame.
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 7,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_ss,
  input  logic              rx_strobe,
  input  logic [BYTE_W-1:0] rx_data,
  output logic [BYTE_W-1:0] tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              frame_ok,
  output logic              frame_err
);

  frame_state_e state;
  logic         rd_capture;

`ifdef SPI_FRAME_CRC_EN
  logic [BYTE_W-1:0] crc;
  logic [BYTE_W-1:0] crc_byte_c;
  logic [BYTE_W-1:0] crc_next_c;

  // Read data and received bytes never arrive in the same cycle, so one step suffices.
  assign crc_byte_c = rd_capture ? reg_rdata : rx_data;

  crc8_byte_step u_crc8_byte_step (
    .crc        (crc),
    .data       (crc_byte_c),
    .crc_next_c (crc_next_c)
  );
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tx_data    <= SYNC_BYTE;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      frame_ok   <= 1'b0;
      rd_capture <= 1'b0;
`ifdef SPI_FRAME_CRC_EN
      crc        <= '0;
      frame_err  <= 1'b0;
`endif
    end else begin
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      frame_ok   <= 1'b0;
      rd_capture <= reg_re;
`ifdef SPI_FRAME_CRC_EN
      frame_err  <= 1'b0;
`endif
      if (spi_ss) begin
        state      <= IDLE;
        tx_data    <= SYNC_BYTE;
        rd_capture <= 1'b0;
`ifdef SPI_FRAME_CRC_EN
        crc        <= '0;
`endif
      end else begin
        // Register file answers one cycle after reg_re.
        if (rd_capture) begin
          tx_data <= reg_rdata;
`ifdef SPI_FRAME_CRC_EN
          crc     <= crc_next_c;
`endif
        end
        if (rx_strobe) begin
          case (state)
            IDLE: begin
              reg_addr <= rx_data[ADDR_W-1:0];
`ifdef SPI_FRAME_CRC_EN
              crc      <= crc_next_c;
`endif
              if (rx_data[CMD_WR_BIT]) begin
                state <= WDATA;
              end else begin
                reg_re <= 1'b1;
                state  <= RDATA;
              end
            end
            WDATA: begin
              reg_wdata <= rx_data;
`ifdef SPI_FRAME_CRC_EN
              crc       <= crc_next_c;
              state     <= WCRC;
`else
              reg_we    <= 1'b1;
              frame_ok  <= 1'b1;
              state     <= DONE;
`endif
            end
`ifdef SPI_FRAME_CRC_EN
            WCRC: begin
              if (rx_data == crc) begin
                reg_we   <= 1'b1;
                frame_ok <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              state <= DONE;
            end
            RDATA: begin
              tx_data <= crc;
              state   <= RCRC;
            end
            RCRC: begin
              frame_ok <= 1'b1;
              tx_data  <= SYNC_BYTE;
              state    <= DONE;
            end
`else
            RDATA: begin
              frame_ok <= 1'b1;
              tx_data  <= SYNC_BYTE;
              state    <= DONE;
            end
`endif
            DONE: begin
              tx_data <= SYNC_BYTE;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed self-checking bench for spi_frame_ctrl; follows SPI_FRAME_CRC_EN
// to pick the 3-byte (CRC) or 2-byte frame scenarios.
module tb_spi_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       spi_ss;
  logic       rx_strobe;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       frame_ok;
  logic       frame_err;

  logic [7:0] rd_val;
  int         pass_cnt;
  int         total_cnt;

  spi_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .spi_ss    (spi_ss),
    .rx_strobe (rx_strobe),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: data valid only in the cycle after reg_re, junk otherwise.
  always @(posedge clk) reg_rdata <= reg_re ? rd_val : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    step();
    rx_strobe = 1'b0;
  endtask

  task automatic end_frame();
    spi_ss = 1'b1;
    step();
    spi_ss = 1'b0;
    idle(2);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    spi_ss    = 1'b1;
    rx_strobe = 1'b0;
    rx_data   = 8'h00;
    rd_val    = 8'h00;

    idle(2);
    chk("rst_tx", tx_data, 8'hA5);
    chk("rst_addr", 8'(reg_addr), 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_we", 8'(reg_we), 8'h00);
    chk("rst_re", 8'(reg_re), 8'h00);
    chk("rst_ok", 8'(frame_ok), 8'h00);
    chk("rst_err", 8'(frame_err), 8'h00);
    rst = 1'b1;
    step();
    spi_ss = 1'b0;
    idle(2);

`ifdef SPI_FRAME_CRC_EN
    // Good write: CRC-8 over {81,00} is A3.
    send_byte(8'h81);
    chk("w_cmd_addr", 8'(reg_addr), 8'h01);
    chk("w_cmd_we", 8'(reg_we), 8'h00);
    idle(3);
    send_byte(8'h00);
    chk("w_data_we", 8'(reg_we), 8'h00);
    idle(3);
    send_byte(8'hA3);
    chk("w_crc_we", 8'(reg_we), 8'h01);
    chk("w_crc_ok", 8'(frame_ok), 8'h01);
    chk("w_crc_err", 8'(frame_err), 8'h00);
    chk("w_crc_addr", 8'(reg_addr), 8'h01);
    chk("w_crc_wdata", reg_wdata, 8'h00);
    chk("w_crc_tx", tx_data, 8'hA5);
    step();
    chk("w_we_pulse", 8'(reg_we), 8'h00);
    chk("w_ok_pulse", 8'(frame_ok), 8'h00);
    idle(2);
    send_byte(8'h99);
    chk("w_extra_we", 8'(reg_we), 8'h00);
    end_frame();

    // Bad CRC byte.
    send_byte(8'h81);
    idle(3);
    send_byte(8'h00);
    idle(3);
    send_byte(8'hA4);
    chk("bad_err", 8'(frame_err), 8'h01);
    chk("bad_we", 8'(reg_we), 8'h00);
    chk("bad_ok", 8'(frame_ok), 8'h00);
    step();
    chk("bad_err_pulse", 8'(frame_err), 8'h00);
    end_frame();

    // Read: CRC-8 over {05,00} is 41.
    rd_val = 8'h00;
    send_byte(8'h05);
    chk("r_re", 8'(reg_re), 8'h01);
    chk("r_addr", 8'(reg_addr), 8'h05);
    chk("r_we", 8'(reg_we), 8'h00);
    step();
    chk("r_re_pulse", 8'(reg_re), 8'h00);
    chk("r_tx_t2", tx_data, 8'hA5);
    step();
    chk("r_tx_t3", tx_data, 8'h00);
    idle(2);
    send_byte(8'hFF);
    chk("r_tx_crc", tx_data, 8'h41);
    chk("r_dummy_ok", 8'(frame_ok), 8'h00);
    idle(3);
    send_byte(8'h41);
    chk("r_ok", 8'(frame_ok), 8'h01);
    chk("r_tx_sync", tx_data, 8'hA5);
    end_frame();

    // Abort before the CRC byte, then a clean write.
    send_byte(8'h81);
    idle(3);
    send_byte(8'h55);
    chk("ab_wdata", reg_wdata, 8'h55);
    spi_ss = 1'b1;
    step();
    chk("ab_we", 8'(reg_we), 8'h00);
    chk("ab_tx", tx_data, 8'hA5);
    spi_ss = 1'b0;
    idle(2);
    send_byte(8'h81);
    idle(3);
    send_byte(8'h00);
    idle(3);
    send_byte(8'hA3);
    chk("ab_next_we", 8'(reg_we), 8'h01);
    chk("ab_next_wdata", reg_wdata, 8'h00);
    chk("ab_next_ok", 8'(frame_ok), 8'h01);
    end_frame();
`else
    // Two-byte write.
    send_byte(8'h82);
    chk("w_cmd_addr", 8'(reg_addr), 8'h02);
    chk("w_cmd_we", 8'(reg_we), 8'h00);
    idle(3);
    send_byte(8'h7F);
    chk("w_we", 8'(reg_we), 8'h01);
    chk("w_ok", 8'(frame_ok), 8'h01);
    chk("w_err", 8'(frame_err), 8'h00);
    chk("w_addr", 8'(reg_addr), 8'h02);
    chk("w_wdata", reg_wdata, 8'h7F);
    chk("w_tx", tx_data, 8'hA5);
    step();
    chk("w_we_pulse", 8'(reg_we), 8'h00);
    idle(2);
    send_byte(8'h11);
    chk("w_extra_we", 8'(reg_we), 8'h00);
    chk("w_extra_ok", 8'(frame_ok), 8'h00);
    chk("w_extra_wdata", reg_wdata, 8'h7F);
    end_frame();

    // Two-byte read.
    rd_val = 8'h3C;
    send_byte(8'h05);
    chk("r_re", 8'(reg_re), 8'h01);
    chk("r_addr", 8'(reg_addr), 8'h05);
    step();
    chk("r_re_pulse", 8'(reg_re), 8'h00);
    chk("r_tx_t2", tx_data, 8'hA5);
    step();
    chk("r_tx_t3", tx_data, 8'h3C);
    idle(2);
    send_byte(8'hFF);
    chk("r_ok", 8'(frame_ok), 8'h01);
    chk("r_re_dummy", 8'(reg_re), 8'h00);
    chk("r_tx_sync", tx_data, 8'hA5);
    end_frame();

    // Abort after the command byte, then a clean write.
    send_byte(8'h81);
    spi_ss = 1'b1;
    step();
    chk("ab_we", 8'(reg_we), 8'h00);
    chk("ab_tx", tx_data, 8'hA5);
    spi_ss = 1'b0;
    idle(2);
    send_byte(8'h83);
    idle(3);
    send_byte(8'h12);
    chk("ab_next_we", 8'(reg_we), 8'h01);
    chk("ab_next_addr", 8'(reg_addr), 8'h03);
    chk("ab_next_wdata", reg_wdata, 8'h12);
    end_frame();
`endif

    // Reset one cycle after reg_re, before read data is captured.
    rd_val = 8'h77;
    send_byte(8'h06);
    chk("rr_re", 8'(reg_re), 8'h01);
    step();
    rst = 1'b0;
    step();
    chk("rr_tx", tx_data, 8'hA5);
    chk("rr_re_low", 8'(reg_re), 8'h00);
    chk("rr_ok", 8'(frame_ok), 8'h00);
    chk("rr_addr", 8'(reg_addr), 8'h00);
    rst = 1'b1;
    idle(2);
    chk("rr_tx_hold", tx_data, 8'hA5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
